// File: rtl/vic_pkg.sv
// Shared types and constants for the vectored interrupt controller.
// Holds the FSM state encoding and the vector/index widths.
package vic_pkg;

    localparam int VEC_W = 16;
    localparam int N_MAX = 16;
    localparam int IDX_W = $clog2(N_MAX);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        ACK,
        DONE
    } state_e;

endpackage

// File: rtl/vic_arbiter.sv
// Combinational arbiter: lowest eligible index at or after ptr_i, wrapping.
// Ports: elig_i (eligible mask), ptr_i (start index) -> valid_o, win_o.
module vic_arbiter
    import vic_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]     elig_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic             valid_o,
    output logic [IDX_W-1:0] win_o
);

    logic [N-1:0] hi_mask;
    logic [N-1:0] hi;
    logic [N-1:0] pick;

    // Searching the upper part first, then the whole vector, is the same
    // as rotating by ptr, priority-encoding and rotating back.
    always_comb begin
        hi_mask = '0;
        for (int i = 0; i < N; i++) begin
            hi_mask[i] = (IDX_W'(i) >= ptr_i);
        end
        hi      = elig_i & hi_mask;
        pick    = (|hi) ? hi : elig_i;
        valid_o = |elig_i;
        win_o   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (pick[i]) begin
                win_o = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/vic_prio.sv
// Vectored interrupt controller: N channels, edge/level, fixed or RR priority.
// Ports: clk_sys/reset/ce, ivec/ireq/iack, irq_o, stb_i/ack_o/dat_o,
// mask_we/mask_din only when VIC_MASK_EN is defined (runtime channel mask).
module vic_prio
    import vic_pkg::*;
#(
    parameter int              N         = 4,
    parameter logic [N-1:0]    EDGE_MASK = '0,
    parameter bit              RR_EN     = 1'b0,
    parameter logic [VEC_W-1:0] SPUR_VEC = 16'o000000
) (
    input  logic               clk_sys,
    input  logic               reset,
    input  logic               ce,
    input  logic [VEC_W*N-1:0] ivec,
    input  logic [N-1:0]       ireq,
    output logic [N-1:0]       iack,
    output logic               irq_o,
    input  logic               stb_i,
    output logic               ack_o,
    output logic [VEC_W-1:0]   dat_o
`ifdef VIC_MASK_EN
    ,
    input  logic               mask_we,
    input  logic [N-1:0]       mask_din
`endif
);

    state_e             state_q, state_d;
    logic [N-1:0]       pend_q, pend_d;
    logic [N-1:0]       prev_q, prev_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic               irq_q, irq_d;
    logic               ack_q, ack_d;
    logic [VEC_W-1:0]   dat_q, dat_d;
    logic [N-1:0]       iack_q;
    logic [N-1:0]       mask;
    logic [N-1:0]       elig;
    logic [N-1:0]       gnt;
    logic               win_vld;
    logic [IDX_W-1:0]   win;
    logic [IDX_W-1:0]   ptr_nxt;
    logic [VEC_W-1:0]   win_vec;
    logic               take;

`ifdef VIC_MASK_EN
    logic [N-1:0] mask_q;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            mask_q <= '0;
        end else if (mask_we) begin
            mask_q <= mask_din;
        end
    end

    assign mask = mask_q;
`else
    assign mask = '0;
`endif

    assign elig = pend_q & ~mask;

    vic_arbiter #(
        .N (N)
    ) u_arb (
        .elig_i  (elig),
        .ptr_i   (ptr_q),
        .valid_o (win_vld),
        .win_o   (win)
    );

    assign ptr_nxt = (win == IDX_W'(N - 1)) ? '0 : win + 1'b1;

    always_comb begin
        win_vec = '0;
        gnt     = '0;
        for (int i = 0; i < N; i++) begin
            if (win == IDX_W'(i)) begin
                win_vec = ivec[VEC_W*i +: VEC_W];
                gnt[i]  = take;
            end
        end
    end

    // Edge channels hold until granted; a new rise on the grant ce wins
    // over the clear. Level channels simply mirror the sampled line.
    always_comb begin
        pend_d = pend_q;
        prev_d = prev_q;
        if (ce) begin
            prev_d = ireq;
            pend_d = (pend_q & ~gnt & EDGE_MASK)
                   | (ireq & ~prev_q & EDGE_MASK)
                   | (ireq & ~EDGE_MASK);
        end
    end

    always_comb begin
        state_d = state_q;
        irq_d   = irq_q;
        ack_d   = ack_q;
        dat_d   = dat_q;
        ptr_d   = ptr_q;
        take    = 1'b0;
        if (ce) begin
            unique case (state_q)
                IDLE: begin
                    if (|elig) begin
                        state_d = REQ;
                        irq_d   = 1'b1;
                    end
                end
                REQ: begin
                    if (stb_i) begin
                        state_d = ACK;
                        irq_d   = 1'b0;
                        ack_d   = 1'b1;
                        if (win_vld) begin
                            take  = 1'b1;
                            dat_d = win_vec;
                            if (RR_EN) begin
                                ptr_d = ptr_nxt;
                            end
                        end else begin
                            dat_d = SPUR_VEC;
                        end
                    end else if (!(|elig)) begin
                        state_d = IDLE;
                        irq_d   = 1'b0;
                    end
                end
                ACK: begin
                    if (!stb_i) begin
                        state_d = DONE;
                        ack_d   = 1'b0;
                        dat_d   = '0;
                    end
                end
                DONE: begin
                    // Gap so irq_o cannot reassert in the same bus cycle.
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q <= IDLE;
            pend_q  <= '0;
            prev_q  <= '0;
            ptr_q   <= '0;
            irq_q   <= 1'b0;
            ack_q   <= 1'b0;
            dat_q   <= '0;
            iack_q  <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            prev_q  <= prev_d;
            ptr_q   <= ptr_d;
            irq_q   <= irq_d;
            ack_q   <= ack_d;
            dat_q   <= dat_d;
            // Not gated by ce: the grant pulse lasts one clk_sys cycle.
            iack_q  <= gnt;
        end
    end

    assign iack  = iack_q;
    assign irq_o = irq_q;
    assign ack_o = ack_q;
    assign dat_o = dat_q;

endmodule

// File: tb/tb_vic_prio.sv
// Self-checking bench for vic_prio: fixed-priority/edge instance A and
// round-robin instance B, table vectors plus scoreboarded vector fetches.
module tb_vic_prio;

    localparam logic [15:0] SPUR = 16'o177776;

    typedef struct {
        logic [15:0] vec;
        logic [3:0]  iack;
    } exp_t;

    typedef struct {
        logic [3:0] ireq;
        int         ch;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset, ce;
    logic [63:0] ivec_a, ivec_b;
    logic [3:0]  ireq_a, ireq_b, iack_a, iack_b;
    logic        irq_a, irq_b, stb_a, stb_b, ack_a, ack_b;
    logic [15:0] dat_a, dat_b;
    logic        mask_we_a, mask_we_b;
    logic [3:0]  mask_din_a, mask_din_b;

    int checks = 0;
    int failures = 0;

    exp_t exp_a[$];
    exp_t exp_b[$];
    exp_t ea, eb;
    logic ack_a_p = 1'b0, ack_b_p = 1'b0;
    logic [3:0] iack_a_p = '0, iack_b_p = '0;

    always #5 clk = ~clk;

    vic_prio #(
        .N(4), .EDGE_MASK(4'b0001), .RR_EN(1'b0), .SPUR_VEC(SPUR)
    ) dut_a (
        .clk_sys(clk), .reset(reset), .ce(ce), .ivec(ivec_a),
        .ireq(ireq_a), .iack(iack_a), .irq_o(irq_a), .stb_i(stb_a),
        .ack_o(ack_a), .dat_o(dat_a)
`ifdef VIC_MASK_EN
        , .mask_we(mask_we_a), .mask_din(mask_din_a)
`endif
    );

    vic_prio #(
        .N(4), .EDGE_MASK(4'b0000), .RR_EN(1'b1), .SPUR_VEC(SPUR)
    ) dut_b (
        .clk_sys(clk), .reset(reset), .ce(ce), .ivec(ivec_b),
        .ireq(ireq_b), .iack(iack_b), .irq_o(irq_b), .stb_i(stb_b),
        .ack_o(ack_b), .dat_o(dat_b)
`ifdef VIC_MASK_EN
        , .mask_we(mask_we_b), .mask_din(mask_din_b)
`endif
    );

    function automatic logic [15:0] vec_a(input int ch);
        return 16'(16'o100 + 4 * ch);
    endfunction

    function automatic logic [15:0] vec_b(input int ch);
        return 16'(16'o200 + 4 * ch);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Scoreboard side: compare each reply on the cycle ack_o rises,
    // and require every iack pulse to be exactly one clock wide.
    always @(negedge clk) begin
        if (ack_a && !ack_a_p) begin
            if (exp_a.size() == 0) begin
                chk("a_unexpected_ack", 32'(ack_a), 32'(0));
            end else begin
                ea = exp_a.pop_front();
                chk("a_sb_dat", 32'(dat_a), 32'(ea.vec));
                chk("a_sb_iack", 32'(iack_a), 32'(ea.iack));
            end
        end
        if (iack_a_p != 0) chk("a_iack_width", 32'(iack_a), 32'(0));
        if (ack_b && !ack_b_p) begin
            if (exp_b.size() == 0) begin
                chk("b_unexpected_ack", 32'(ack_b), 32'(0));
            end else begin
                eb = exp_b.pop_front();
                chk("b_sb_dat", 32'(dat_b), 32'(eb.vec));
                chk("b_sb_iack", 32'(iack_b), 32'(eb.iack));
            end
        end
        if (iack_b_p != 0) chk("b_iack_width", 32'(iack_b), 32'(0));
        ack_a_p  <= ack_a;
        ack_b_p  <= ack_b;
        iack_a_p <= iack_a;
        iack_b_p <= iack_b;
    end

    task automatic wait_irq(input bit b, input string nm);
        int n = 0;
        while (!(b ? irq_b : irq_a) && n < 40) begin
            tick(1);
            n++;
        end
        chk({nm, "_irq"}, 32'(b ? irq_b : irq_a), 32'(1));
    endtask

    // Push the expected reply, run one IAKO cycle, check the bus release.
    task automatic strobe(input bit b, input int ch, input string nm);
        exp_t e;
        int n;
        e.vec  = (ch < 0) ? SPUR : (b ? vec_b(ch) : vec_a(ch));
        e.iack = (ch < 0) ? 4'b0000 : 4'(1 << ch);
        if (b) begin
            exp_b.push_back(e);
            stb_b = 1'b1;
        end else begin
            exp_a.push_back(e);
            stb_a = 1'b1;
        end
        n = 0;
        while (!(b ? ack_b : ack_a) && n < 40) begin
            tick(1);
            n++;
        end
        chk({nm, "_ack"}, 32'(b ? ack_b : ack_a), 32'(1));
        tick(1);
        chk({nm, "_hold"}, 32'(b ? dat_b : dat_a), 32'(e.vec));
        if (b) stb_b = 1'b0;
        else stb_a = 1'b0;
        n = 0;
        while ((b ? ack_b : ack_a) && n < 40) begin
            tick(1);
            n++;
        end
        chk({nm, "_ackdrop"}, 32'(b ? ack_b : ack_a), 32'(0));
        chk({nm, "_datzero"}, 32'(b ? dat_b : dat_a), 32'(0));
    endtask

    vec_t tbl[5];
    int   rr_exp[5];

    initial begin
        tbl[0] = '{4'b0110, 1};
        tbl[1] = '{4'b1000, 3};
        tbl[2] = '{4'b1100, 2};
        tbl[3] = '{4'b1110, 1};
        tbl[4] = '{4'b0100, 2};
        rr_exp = '{0, 1, 2, 3, 0};
        for (int i = 0; i < 4; i++) begin
            ivec_a[16*i +: 16] = vec_a(i);
            ivec_b[16*i +: 16] = vec_b(i);
        end
        reset = 1'b1;
        ce = 1'b1;
        ireq_a = '0;
        ireq_b = '0;
        stb_a = 1'b0;
        stb_b = 1'b0;
        mask_we_a = 1'b0;
        mask_we_b = 1'b0;
        mask_din_a = '0;
        mask_din_b = '0;
        tick(3);
        chk("rst_irq", 32'(irq_a), 32'(0));
        chk("rst_ack", 32'(ack_a), 32'(0));
        chk("rst_dat", 32'(dat_a), 32'(0));
        chk("rst_iack", 32'(iack_a), 32'(0));
        chk("rst_irq_b", 32'(irq_b), 32'(0));
        reset = 1'b0;
        tick(2);

        // Latency: pending sampled on one ce, irq_o on the next.
        ireq_a = 4'b0110;
        tick(1);
        chk("lat_irq_early", 32'(irq_a), 32'(0));
        tick(1);
        chk("lat_irq", 32'(irq_a), 32'(1));
        stb_a = 1'b1;
        exp_a.push_back('{vec_a(1), 4'b0010});
        tick(1);
        chk("t1_ack", 32'(ack_a), 32'(1));
        chk("t1_dat", 32'(dat_a), 32'(vec_a(1)));
        chk("t1_iack", 32'(iack_a), 32'(4'b0010));
        chk("t1_irq_low", 32'(irq_a), 32'(0));
        tick(1);
        chk("t1_iack_off", 32'(iack_a), 32'(0));
        ireq_a = '0;
        stb_a = 1'b0;
        tick(4);
        chk("t1_idle", 32'(irq_a), 32'(0));

        // Fixed-priority table on level channels.
        for (int i = 0; i < 5; i++) begin
            ireq_a = tbl[i].ireq;
            wait_irq(1'b0, $sformatf("tbl%0d", i));
            strobe(1'b0, tbl[i].ch, $sformatf("tbl%0d", i));
            ireq_a = '0;
            tick(4);
        end

        // Edge channel: short pulse is remembered, served once.
        ireq_a = 4'b0001;
        tick(1);
        ireq_a = 4'b0000;
        tick(3);
        wait_irq(1'b0, "edge");
        strobe(1'b0, 0, "edge");
        tick(6);
        chk("edge_no_reirq", 32'(irq_a), 32'(0));

        // Withdrawal before the strobe.
        ireq_a = 4'b0100;
        wait_irq(1'b0, "wd");
        ireq_a = 4'b0000;
        tick(2);
        chk("wd_irq_drop", 32'(irq_a), 32'(0));

        // Withdrawal racing the strobe: spurious vector, no iack.
        ireq_a = 4'b0100;
        wait_irq(1'b0, "spur");
        ireq_a = 4'b0000;
        tick(1);
        strobe(1'b0, -1, "spur");
        tick(4);

        // Strobe while idle is ignored.
        stb_a = 1'b1;
        tick(4);
        chk("idle_stb_noack", 32'(ack_a), 32'(0));
        stb_a = 1'b0;
        tick(2);

        // Round-robin on instance B with all requests held.
        ireq_b = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_irq(1'b1, $sformatf("rr%0d", k));
            strobe(1'b1, rr_exp[k], $sformatf("rr%0d", k));
            chk("rr_gap_done", 32'(irq_b), 32'(0));
            tick(1);
            chk("rr_gap_idle", 32'(irq_b), 32'(0));
        end
        ireq_b = 4'b0000;
        tick(4);

        // Reset in the middle of an acknowledge.
        ireq_a = 4'b0010;
        wait_irq(1'b0, "rst_ack");
        exp_a.push_back('{vec_a(1), 4'b0010});
        stb_a = 1'b1;
        tick(2);
        chk("rstack_pre", 32'(ack_a), 32'(1));
        reset = 1'b1;
        tick(1);
        chk("rstack_ack", 32'(ack_a), 32'(0));
        chk("rstack_dat", 32'(dat_a), 32'(0));
        chk("rstack_irq", 32'(irq_a), 32'(0));
        reset = 1'b0;
        stb_a = 1'b0;
        ireq_a = 4'b0000;
        tick(4);

        // Sparse ce: FSM holds between enables, iack stays one clock.
        ce = 1'b0;
        ireq_a = 4'b0010;
        tick(3);
        chk("ce_hold_irq", 32'(irq_a), 32'(0));
        ce = 1'b1;
        tick(1);
        ce = 1'b0;
        tick(3);
        chk("ce_hold_irq2", 32'(irq_a), 32'(0));
        ce = 1'b1;
        tick(1);
        ce = 1'b0;
        chk("ce_irq", 32'(irq_a), 32'(1));
        exp_a.push_back('{vec_a(1), 4'b0010});
        stb_a = 1'b1;
        tick(2);
        chk("ce_no_ack", 32'(ack_a), 32'(0));
        ce = 1'b1;
        tick(1);
        ce = 1'b0;
        chk("ce_ack", 32'(ack_a), 32'(1));
        chk("ce_iack", 32'(iack_a), 32'(4'b0010));
        tick(1);
        chk("ce_iack_1clk", 32'(iack_a), 32'(0));
        chk("ce_ack_hold", 32'(ack_a), 32'(1));
        stb_a = 1'b0;
        ireq_a = 4'b0000;
        ce = 1'b1;
        tick(5);
        chk("ce_release", 32'(ack_a), 32'(0));

`ifdef VIC_MASK_EN
        mask_we_a = 1'b1;
        mask_din_a = 4'b0001;
        tick(1);
        mask_we_a = 1'b0;
        ireq_a = 4'b0011;
        wait_irq(1'b0, "mask");
        strobe(1'b0, 1, "mask");
        mask_we_a = 1'b1;
        mask_din_a = 4'b0000;
        tick(1);
        mask_we_a = 1'b0;
        wait_irq(1'b0, "unmask");
        strobe(1'b0, 0, "unmask");
        ireq_a = 4'b0000;
        tick(4);
`endif

        chk("sb_a_empty", 32'(exp_a.size()), 32'(0));
        chk("sb_b_empty", 32'(exp_b.size()), 32'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
